// File: rtl/rotate_xor_sequencer_if.sv
// Handshake bundle between the round datapath and the rotate-XOR sequencer.
// Signal names follow the sequencer's point of view.
`timescale 1ns/1ps
interface rotate_xor_sequencer_if;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  mode_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result_out;
  logic        busy_out;

  modport slave (
    input  valid_in, mode_in, data_in, ready_in,
    output ready_out, valid_out, result_out, busy_out
  );

  modport master (
    output valid_in, mode_in, data_in, ready_in,
    input  ready_out, valid_out, result_out, busy_out
  );
endinterface

// File: rtl/rotate_xor_sequencer.sv
// SM4 L / L' and SM3 P0 / P1 linear transforms computed by stepping one
// shared 32-bit rotator through the per-mode rotation table.
`timescale 1ns/1ps
module barrel_shifter (
  input  logic [31:0] data_in,
  input  logic [4:0]  shift_number_in,
  output logic [31:0] data_out
);
  assign data_out = (data_in << shift_number_in) |
                    (data_in >> (6'd32 - {1'b0, shift_number_in}));
endmodule

// state  | meaning
// S_IDLE | ready for a new word
// S_ROT  | one rotation folded into the accumulator per cycle
// S_DONE | result presented, waiting for ready_in
module rotate_xor_sequencer (
  input logic                    clk_in,
  input logic                    reset_n_in,
  rotate_xor_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_data;
  logic [1:0]  r_mode;
  logic [31:0] r_acc;
  logic [1:0]  r_idx;
  logic        r_ready;
  logic        r_valid;
  logic        r_busy;
  logic [31:0] r_result;

  logic [4:0]  w_shift_amt;
  logic [1:0]  w_last_idx;
  logic        w_last;
  logic [31:0] w_rot;
  logic [31:0] w_acc_next;

  // Unused slots of the two-rotation modes map to 0; idx never reaches them.
  always_comb begin
    w_shift_amt = 5'd0;
    case ({r_mode, r_idx})
      4'b00_00: w_shift_amt = 5'd2;
      4'b00_01: w_shift_amt = 5'd10;
      4'b00_10: w_shift_amt = 5'd18;
      4'b00_11: w_shift_amt = 5'd24;
      4'b01_00: w_shift_amt = 5'd13;
      4'b01_01: w_shift_amt = 5'd23;
      4'b10_00: w_shift_amt = 5'd9;
      4'b10_01: w_shift_amt = 5'd17;
      4'b11_00: w_shift_amt = 5'd15;
      4'b11_01: w_shift_amt = 5'd23;
      default:  w_shift_amt = 5'd0;
    endcase
  end

  assign w_last_idx = (r_mode == 2'd0) ? 2'd3 : 2'd1;
  assign w_last     = (r_idx == w_last_idx);
  assign w_acc_next = r_acc ^ w_rot;

  barrel_shifter u_shifter (
    .data_in         (r_data),
    .shift_number_in (w_shift_amt),
    .data_out        (w_rot)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state  <= S_IDLE;
      r_data   <= 32'd0;
      r_mode   <= 2'd0;
      r_acc    <= 32'd0;
      r_idx    <= 2'd0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_in && r_ready) begin
            r_data  <= bus.data_in;
            r_mode  <= bus.mode_in;
            r_acc   <= bus.data_in;
            r_idx   <= 2'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_ROT;
          end
        end
        S_ROT: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_result <= w_acc_next;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        S_DONE: begin
          // Returning through IDLE costs one bubble before the next accept.
          if (bus.ready_in) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out  = r_ready;
  assign bus.valid_out  = r_valid;
  assign bus.busy_out   = r_busy;
  assign bus.result_out = r_result;
endmodule

// File: tb/tb_rotate_xor_sequencer.sv
// Directed bench for rotate_xor_sequencer with hand-computed transform results.
`timescale 1ns/1ps
module tb_rotate_xor_sequencer;
  logic clk_in = 1'b0;
  logic reset_n_in = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lat;

  rotate_xor_sequencer_if bus ();

  rotate_xor_sequencer dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Called #1 after the accepting edge; counts edges until valid_out rises.
  task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp);
    lat = 0;
    while (bus.valid_out !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, bus.result_out, exp);
    chk({tag, "_rdy"}, {31'd0, bus.ready_out}, 32'd0);
  endtask

  task automatic txn(input string tag, input logic [1:0] m, input logic [31:0] d,
                     input int exp_lat, input logic [31:0] exp);
    bus.valid_in = 1'b1;
    bus.mode_in  = m;
    bus.data_in  = d;
    chk({tag, "_acc_rdy"}, {31'd0, bus.ready_out}, 32'd1);
    step();
    bus.valid_in = 1'b0;
    chk({tag, "_busy"}, {31'd0, bus.busy_out}, 32'd1);
    wait_result(tag, exp_lat, exp);
    step();
    chk({tag, "_idle_vld"}, {31'd0, bus.valid_out}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'd0, bus.ready_out}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_in = 1'b1;
    bus.mode_in  = 2'd0;
    bus.data_in  = 32'h0000_0001;
    bus.ready_in = 1'b1;

    // Reset held with valid_in asserted
    repeat (3) step();
    chk("rst_rdy",  {31'd0, bus.ready_out}, 32'd1);
    chk("rst_vld",  {31'd0, bus.valid_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_out},  32'd0);
    chk("rst_res",  bus.result_out,         32'd0);
    reset_n_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    chk("post_rst_accept_rdy",  {31'd0, bus.ready_out}, 32'd0);
    chk("post_rst_accept_busy", {31'd0, bus.busy_out},  32'd1);
    wait_result("m0_one", 4, 32'h0104_0405);
    step();

    txn("m0_msb", 2'd0, 32'h8000_0000, 4, 32'h8082_0202);
    txn("m2_one", 2'd2, 32'h0000_0001, 2, 32'h0002_0201);
    txn("m3_one", 2'd3, 32'h0000_0001, 2, 32'h0080_8001);
    txn("m1_one", 2'd1, 32'h0000_0001, 2, 32'h0080_2001);
    txn("m2_msb", 2'd2, 32'h8000_0000, 2, 32'h8001_0100);

    // Backpressure: hold ready_in low in DONE, with a competing valid_in
    bus.ready_in = 1'b0;
    bus.valid_in = 1'b1;
    bus.mode_in  = 2'd0;
    bus.data_in  = 32'h0000_0003;
    step();
    bus.mode_in  = 2'd2;
    bus.data_in  = 32'h0000_0001;
    wait_result("bp", 4, 32'h030C_0C0F);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_vld", {31'd0, bus.valid_out}, 32'd1);
      chk("bp_hold_res", bus.result_out, 32'h030C_0C0F);
      chk("bp_hold_rdy", {31'd0, bus.ready_out}, 32'd0);
    end
    bus.ready_in = 1'b1;
    step();
    chk("bp_rel_vld",  {31'd0, bus.valid_out}, 32'd0);
    chk("bp_rel_rdy",  {31'd0, bus.ready_out}, 32'd1);
    chk("bp_rel_busy", {31'd0, bus.busy_out},  32'd0);
    step();
    bus.valid_in = 1'b0;
    chk("bp_next_accept", {31'd0, bus.ready_out}, 32'd0);
    wait_result("bp_next", 2, 32'h0002_0201);
    step();

    // Input churn after accept
    bus.valid_in = 1'b1;
    bus.mode_in  = 2'd3;
    bus.data_in  = 32'h0000_0001;
    step();
    bus.valid_in = 1'b0;
    bus.mode_in  = 2'd0;
    bus.data_in  = 32'hFFFF_FFFF;
    wait_result("churn", 2, 32'h0080_8001);
    step();

    // Reset during the second ROT cycle of mode0
    bus.valid_in = 1'b1;
    bus.mode_in  = 2'd0;
    bus.data_in  = 32'h0000_0001;
    step();
    bus.valid_in = 1'b0;
    step();
    #2;
    reset_n_in = 1'b0;
    #1;
    chk("mid_rst_rdy",  {31'd0, bus.ready_out}, 32'd1);
    chk("mid_rst_vld",  {31'd0, bus.valid_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy_out},  32'd0);
    chk("mid_rst_res",  bus.result_out,         32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_no_vld", {31'd0, bus.valid_out}, 32'd0);
    end
    reset_n_in = 1'b1;
    step();
    chk("mid_rst_idle_rdy", {31'd0, bus.ready_out}, 32'd1);
    txn("after_rst", 2'd1, 32'h0000_0001, 2, 32'h0080_2001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
